// File: rtl/weight_loader.sv
// Weight loader: fetches FIFO_DEPTH rows from weight memory starting at a
// latched base address and pushes them, in order, into the downstream
// weight FIFO with a fixed read-to-push latency of two cycles.
module weight_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_INPUTS = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic                              pause,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH*FIFO_INPUTS-1:0] mem_rd_data,
    output logic                              fifo_en,
    output logic [DATA_WIDTH*FIFO_INPUTS-1:0] fifo_data,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned BUS_W = DATA_WIDTH * FIFO_INPUTS;
    localparam int unsigned ROW_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [ROW_W-1:0]      row_q,       row_d;
    logic [ADDR_WIDTH-1:0] base_q,      base_d;
    logic                  rd_pend_q,   rd_pend_d;
    logic                  fifo_en_q,   fifo_en_d;
    logic [BUS_W-1:0]      fifo_data_q, fifo_data_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  rd_issue_c;

    // Read strobe must react to pause in the same cycle, so it is combinational.
    assign rd_issue_c = (state_q == ST_FETCH) && !pause;
    assign mem_rd_en  = rd_issue_c;
    assign mem_addr   = base_q + ADDR_WIDTH'(row_q);

    assign fifo_en    = fifo_en_q;
    assign fifo_data  = fifo_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        base_d      = base_q;
        rd_pend_d   = rd_issue_c;
        fifo_en_d   = rd_pend_q;
        fifo_data_d = rd_pend_q ? mem_rd_data : fifo_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    base_d  = base_addr;
                    row_d   = '0;
                end
            end
            ST_FETCH: begin
                if (!pause) begin
                    row_d = ROW_W'(row_q + 1'b1);
                    if (row_q == ROW_W'(FIFO_DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Reads stopped on DRAIN entry; the push with nothing behind it is the last.
                if (fifo_en_q && !rd_pend_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset also flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            base_q      <= '0;
            rd_pend_q   <= 1'b0;
            fifo_en_q   <= 1'b0;
            fifo_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            base_q      <= base_d;
            rd_pend_q   <= rd_pend_d;
            fifo_en_q   <= fifo_en_d;
            fifo_data_q <= fifo_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader with default parameters.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic        pause;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        fifo_en;
    logic [31:0] fifo_data;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  addr_q[$];
    logic [31:0] data_q[$];
    logic [31:0] last_push;

    weight_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .pause       (pause),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .fifo_en     (fifo_en),
        .fifo_data   (fifo_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Address-tagged row: lane i carries addr+i.
    function automatic logic [31:0] row_of(input logic [7:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(a + 8'(i));
        return r;
    endfunction

    // Memory model: one-cycle read latency, holds last data otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= row_of(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Per-cycle sampled checks of reads and pushes against the scoreboard.
    task automatic check_traffic(input int c, input logic [15:0] exp_rd, input logic [15:0] exp_push);
        logic [7:0]  ea;
        logic [31:0] ed;
        check_eq($sformatf("rd_en c%0d", c), 32'(mem_rd_en), 32'(exp_rd[c]));
        if (mem_rd_en) begin
            if (addr_q.size() == 0) check_eq("extra_read", 32'(addr_q.size()), 32'd1);
            else begin
                ea = addr_q.pop_front();
                check_eq($sformatf("addr c%0d", c), 32'(mem_addr), 32'(ea));
            end
        end
        check_eq($sformatf("fifo_en c%0d", c), 32'(fifo_en), 32'(exp_push[c]));
        if (fifo_en) begin
            if (data_q.size() == 0) check_eq("extra_push", 32'(data_q.size()), 32'd1);
            else begin
                ed = data_q.pop_front();
                check_eq($sformatf("data c%0d", c), fifo_data, ed);
                last_push = ed;
            end
        end else begin
            check_eq($sformatf("hold c%0d", c), fifo_data, last_push);
        end
    endtask

    // One load: start accepted at E0, then ncyc cycles of per-cycle checks.
    task automatic run_load(input logic [7:0] base, input logic [15:0] pause_m,
                            input logic [15:0] start_m, input logic [15:0] exp_rd,
                            input logic [15:0] exp_push, input int done_cyc, input int ncyc);
        for (int r = 0; r < 4; r++) begin
            addr_q.push_back(8'(base + 8'(r)));
            data_q.push_back(row_of(8'(base + 8'(r))));
        end
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            pause = pause_m[c];
            start = start_m[c];
            base_addr = 8'($urandom);
            @(negedge clk);
            check_traffic(c, exp_rd, exp_push);
            check_eq($sformatf("done c%0d", c), 32'(done), 32'(c == done_cyc));
            check_eq($sformatf("busy c%0d", c), 32'(busy), 32'(c <= done_cyc));
            @(posedge clk); #1;
        end
        start = 1'b0;
        pause = 1'b0;
        check_eq("reads_left", 32'(addr_q.size()), 32'd0);
        check_eq("pushes_left", 32'(data_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pause = 1'b0; base_addr = 8'h00;
        mem_rd_data = 32'hA5A5A5A5;
        last_push = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst fifo_en", 32'(fifo_en), 32'd0);
        check_eq("rst fifo_data", fifo_data, 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic load, address wrap, pause window, ignored re-starts.
        run_load(8'h10, 16'h0000, 16'h0000, 16'h001E, 16'h0078, 7, 9);
        run_load(8'hFE, 16'h0000, 16'h0000, 16'h001E, 16'h0078, 7, 9);
        run_load(8'h30, 16'h000C, 16'h0000, 16'h0072, 16'h01C8, 9, 11);
        run_load(8'h50, 16'h0000, 16'h00E4, 16'h001E, 16'h0078, 7, 10);

        // Reset asserted during cycle 3 of a load.
        for (int r = 0; r < 4; r++) begin
            addr_q.push_back(8'(8'h20 + 8'(r)));
            data_q.push_back(row_of(8'(8'h20 + 8'(r))));
        end
        start = 1'b1; base_addr = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) reset = 1'b0;
            @(negedge clk);
            check_traffic(c, 16'h000E, 16'h0008);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        addr_q.delete();
        data_q.delete();
        last_push = 32'h0;
        @(negedge clk);
        check_eq("postrst mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("postrst mem_addr", 32'(mem_addr), 32'd0);
        check_eq("postrst fifo_en", 32'(fifo_en), 32'd0);
        check_eq("postrst fifo_data", fifo_data, 32'd0);
        check_eq("postrst busy", 32'(busy), 32'd0);
        check_eq("postrst done", 32'(done), 32'd0);
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("postrst fifo_en c%0d", c), 32'(fifo_en), 32'd0);
            check_eq($sformatf("postrst busy c%0d", c), 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        run_load(8'h40, 16'h0000, 16'h0000, 16'h001E, 16'h0078, 7, 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per weight.
REQ-002 SHALL have parameter FIFO_INPUTS, default 4, weights per row (lanes).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, rows per load operation.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, weight-memory address width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  address of row 0, latched on accepted start.
REQ-009 SHALL have port pause  input  1  when high in FETCH, no new read is issued.
REQ-010 SHALL have port mem_rd_en  output  1  weight-memory read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  weight-memory read address.
REQ-012 SHALL have port mem_rd_data  input  DATA_WIDTH*FIFO_INPUTS  read data, valid the cycle after mem_rd_en.
REQ-013 SHALL have port fifo_en  output  1  push/shift strobe to the downstream weight FIFO.
REQ-014 SHALL have port fifo_data  output  DATA_WIDTH*FIFO_INPUTS  row pushed into the weight FIFO.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-018 IDLE: start=1 SHALL latch base_addr, clear row counter, enter FETCH next cycle.
REQ-019 start SHALL be ignored in FETCH, DRAIN, DONE; no queuing.
REQ-020 FETCH, pause=0: mem_rd_en=1, mem_addr=latched base_addr+row counter, row counter increments.
REQ-021 FETCH, pause=1: mem_rd_en=0, row counter and mem_addr hold; state stays FETCH.
REQ-022 Address addition SHALL wrap modulo 2^ADDR_WIDTH.
REQ-023 FETCH SHALL exit to DRAIN in the cycle after the read of row FIFO_DEPTH-1 is issued.
REQ-024 Each read issued in cycle t SHALL have mem_rd_data registered into fifo_data at end of cycle t+1, with fifo_en=1 in cycle t+2 (read-to-push latency 2).
REQ-025 pause SHALL NOT affect reads already issued; their pushes complete on schedule.
REQ-026 Rows SHALL be pushed in ascending address order, exactly FIFO_DEPTH pushes per load.
REQ-027 fifo_data SHALL hold its last value when fifo_en=0.
REQ-028 DRAIN SHALL exit to DONE in the cycle after the final push (fifo_en for row FIFO_DEPTH-1).
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 done SHALL be 0 in all other states; busy=1 in FETCH, DRAIN, DONE.
REQ-031 With pause held 0, start accepted at edge E0: mem_rd_en cycles 1..FIFO_DEPTH, fifo_en cycles 3..FIFO_DEPTH+2, done cycle FIFO_DEPTH+3.

Reset
REQ-032 reset=0 at a posedge SHALL force IDLE, row counter 0, latched address 0.
REQ-033 Reset values: mem_rd_en=0, mem_addr=0, fifo_en=0, fifo_data=0, busy=0, done=0.
REQ-034 Reset mid-operation SHALL discard in-flight reads; no fifo_en asserted for them after reset.
REQ-035 reset SHALL take priority over start and pause.

Verification
REQ-036 Defaults, base_addr=0x10, start pulse, pause=0, memory returns addr-tagged rows -> reads 0x10..0x13 cycles 1..4, pushes rows 0x10..0x13 cycles 3..6, done=1 cycle 7 only, busy cycles 1..7.
REQ-037 base_addr=0xFE -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; four pushes in that order.
REQ-038 pause=1 cycles 2..3 during FETCH -> reads issued cycles 1,4,5,6; pushes cycles 3,6,7,8; done cycle 9; no row lost or duplicated.
REQ-039 start re-pulsed during FETCH and DRAIN -> ignored; exactly 4 pushes, one done pulse.
REQ-040 reset=0 in cycle 3 of a load -> all outputs 0 next cycle, no further fifo_en; subsequent start performs a clean full load.
